wb_cfg_master: RTL

WB_CFG_MASTER -- requirements
Module: wb_cfg_master

---
 rtl/wb_cfg_master.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/wb_cfg_master.sv
// Single-outstanding command-to-Wishbone-classic bridge (cyc/stb master).
// Optional WB_CFG_MASTER_TIMEOUT_EN adds a per-transaction ack timeout.
module wb_cfg_master #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        wb_clk_i,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [31:0] cmd_adr,
  input  logic [31:0] cmd_dat,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_dat,
  output logic        rsp_err,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic        wbm_ack_i,
  input  logic [31:0] wbm_dat_i
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUS,
    S_RESP
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic        cyc_d;
  logic        we_d;
  logic [31:0] adr_d;
  logic [31:0] dat_d;
  logic [31:0] rdat_d;
  logic        rvld_d;
  logic        rerr_d;
  logic        unused_ok;

`ifdef WB_CFG_MASTER_TIMEOUT_EN
  localparam logic [15:0] TO_LIM = 16'(TIMEOUT_CYCLES);
  logic [15:0] cnt_q;
  logic [15:0] cnt_d;
  assign unused_ok = ^cmd_adr[1:0];
`else
  assign unused_ok = ^{cmd_adr[1:0], (TIMEOUT_CYCLES != 0)};
`endif

  // Next-state and next-output decode; every register holds by default.
  always_comb begin
    state_d = state_q;
    cyc_d   = wbm_cyc_o;
    we_d    = wbm_we_o;
    adr_d   = wbm_adr_o;
    dat_d   = wbm_dat_o;
    rdat_d  = rsp_dat;
    rvld_d  = rsp_valid;
    rerr_d  = rsp_err;
`ifdef WB_CFG_MASTER_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          state_d = S_BUS;
          cyc_d   = 1'b1;
          we_d    = cmd_we;
          adr_d   = {cmd_adr[31:2], 2'b00};
          dat_d   = cmd_dat;
`ifdef WB_CFG_MASTER_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      S_BUS: begin
        if (wbm_ack_i) begin
          state_d = S_RESP;
          cyc_d   = 1'b0;
          rdat_d  = wbm_we_o ? '0 : wbm_dat_i;
          rerr_d  = 1'b0;
          rvld_d  = 1'b1;
        end
`ifdef WB_CFG_MASTER_TIMEOUT_EN
        else if (cnt_q + 16'd1 == TO_LIM) begin
          state_d = S_RESP;
          cyc_d   = 1'b0;
          rdat_d  = '0;
          rerr_d  = 1'b1;
          rvld_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
`endif
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
          rvld_d  = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        cyc_d   = 1'b0;
        rvld_d  = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset drops any transaction in flight.
  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cmd_ready <= 1'b1;
      wbm_cyc_o <= 1'b0;
      wbm_we_o  <= 1'b0;
      wbm_sel_o <= 4'h0;
      wbm_adr_o <= '0;
      wbm_dat_o <= '0;
      rsp_valid <= 1'b0;
      rsp_dat   <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cmd_ready <= (state_d == S_IDLE);
      wbm_cyc_o <= cyc_d;
      wbm_we_o  <= we_d;
      wbm_sel_o <= {4{cyc_d}};
      wbm_adr_o <= adr_d;
      wbm_dat_o <= dat_d;
      rsp_valid <= rvld_d;
      rsp_dat   <= rdat_d;
      rsp_err   <= rerr_d;
    end
  end

`ifdef WB_CFG_MASTER_TIMEOUT_EN
  // Ack timeout counter, cleared when a bus cycle starts.
  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`endif

  assign wbm_stb_o = wbm_cyc_o;

endmodule
